// File: rtl/mips_int_pkg.sv
// mips_int_pkg: shared interrupt-controller state encoding and vector defaults
package mips_int_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;
    localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0080;
    localparam int          VEC_SHIFT_DEF = 4;
endpackage

// File: rtl/int_prienc.sv
// int_prienc: combinational lowest-index-first priority encoder
module int_prienc #(
    parameter int NSRC = 4,
    parameter int ID_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [ID_W-1:0] idx
);
    always_comb begin
        valid = |req;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) idx = ID_W'(i);
    end
endmodule

// File: rtl/intreq_ctrl.sv
// intreq_ctrl: edge-detected, masked, priority interrupt request controller
module intreq_ctrl
    import mips_int_pkg::*;
#(
    parameter int          NSRC      = 4,
    parameter int          ID_W      = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
    parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            int_ack,
    input  logic            eoi,
    output logic            interrupt,
    output logic [ID_W-1:0] int_id,
    output logic [31:0]     vector,
    output logic [NSRC-1:0] pending,
    output logic            busy
);
    int_state_t      state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] ack_clr;
    logic            pe_valid;
    logic [ID_W-1:0] pe_idx;

    assign rise = irq_in & ~irq_q;
    // a rise on the acked bit in the same cycle survives the clear
    assign ack_clr = (state == REQ && int_ack) ? (NSRC'(1) << int_id) : '0;

    int_prienc #(.NSRC(NSRC), .ID_W(ID_W)) u_prienc (
        .req   (pending & ~irq_mask),
        .valid (pe_valid),
        .idx   (pe_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            irq_q     <= '0;
            pending   <= '0;
            interrupt <= 1'b0;
            busy      <= 1'b0;
            int_id    <= '0;
            vector    <= VEC_BASE;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~ack_clr) | rise;
            case (state)
                IDLE: if (pe_valid) begin
                    int_id    <= pe_idx;
                    vector    <= VEC_BASE + (32'(pe_idx) << VEC_SHIFT);
                    interrupt <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (int_ack) begin
                    interrupt <= 1'b0;
                    busy      <= 1'b1;
                    state     <= SERVICE;
                end else if (irq_mask[int_id]) begin
                    interrupt <= 1'b0;
                    state     <= IDLE;
                end
                SERVICE: if (eoi) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intreq_ctrl.sv
// tb_intreq_ctrl: directed and randomized checks against a behavioural model
module tb_intreq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_in = '0;
    logic [3:0]  irq_mask = '0;
    logic        int_ack = 1'b0;
    logic        eoi = 1'b0;
    logic        interrupt;
    logic [1:0]  int_id;
    logic [31:0] vector;
    logic [3:0]  pending;
    logic        busy;
    int checks = 0;
    int failures = 0;

    // behavioural model: which source is on offer, whether a handler runs
    int       m_pres = -1;
    bit       m_insvc = 0;
    int       m_id = 0;
    bit [3:0] m_pend = '0;
    bit [3:0] m_prev = '0;

    intreq_ctrl dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask),
        .int_ack(int_ack), .eoi(eoi), .interrupt(interrupt), .int_id(int_id),
        .vector(vector), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pres = -1; m_insvc = 0; m_id = 0; m_pend = '0; m_prev = '0;
    endtask

    task automatic model_clk();
        bit [3:0] rise = irq_in & ~m_prev;
        if (m_insvc) begin
            if (eoi) m_insvc = 0;
        end else if (m_pres >= 0) begin
            if (int_ack) begin
                m_pend[m_pres] = 0; m_insvc = 1; m_pres = -1;
            end else if (irq_mask[m_pres]) m_pres = -1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && !irq_mask[i] && m_pres < 0) begin
                    m_pres = i; m_id = i;
                end
        end
        m_pend = m_pend | rise;
        m_prev = irq_in;
    endtask

    task automatic step(input logic [3:0] irq, input logic [3:0] mask, input logic ack, input logic e);
        irq_in = irq; irq_mask = mask; int_ack = ack; eoi = e;
        @(posedge clk);
        if (!reset) model_reset(); else model_clk();
        #1;
    endtask

    task automatic test_reset();
        step(4'h0, 4'h0, 0, 0);
        step(4'h0, 4'h0, 0, 0);
        checks++; if ({interrupt, busy, pending, int_id} !== 8'h00) begin failures++; $display("FAIL reset_state got int=%b busy=%b pend=%b id=%0d", interrupt, busy, pending, int_id); end
        checks++; if (vector !== 32'h80) begin failures++; $display("FAIL reset_vector got %h want 00000080", vector); end
        #2 reset = 1'b1;
        step(4'h0, 4'h0, 0, 0);
    endtask

    task automatic test_single();
        step(4'b0100, 4'h0, 0, 0);
        checks++; if (pending !== 4'b0100 || interrupt !== 1'b0) begin failures++; $display("FAIL single_e1 pend=%b int=%b want 0100/0", pending, interrupt); end
        step(4'b0000, 4'h0, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd2 || vector !== 32'h0000_00A0) begin failures++; $display("FAIL single_e2 int=%b id=%0d vec=%h want 1/2/000000a0", interrupt, int_id, vector); end
        step(4'b0000, 4'h0, 1, 0);
        checks++; if (interrupt !== 1'b0 || busy !== 1'b1 || pending !== 4'b0000) begin failures++; $display("FAIL single_ack int=%b busy=%b pend=%b want 0/1/0000", interrupt, busy, pending); end
        step(4'b0000, 4'h0, 0, 1);
        checks++; if (busy !== 1'b0 || interrupt !== 1'b0) begin failures++; $display("FAIL single_eoi busy=%b int=%b want 0/0", busy, interrupt); end
    endtask

    task automatic test_priority();
        step(4'b1010, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd1) begin failures++; $display("FAIL prio_first int=%b id=%0d want 1/1", interrupt, int_id); end
        step(4'b0000, 4'h0, 1, 0);
        step(4'b0000, 4'h0, 0, 1);
        step(4'b0000, 4'h0, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd3 || vector !== 32'h0000_00B0) begin failures++; $display("FAIL prio_second int=%b id=%0d vec=%h want 1/3/000000b0", interrupt, int_id, vector); end
        step(4'b0000, 4'h0, 1, 0);
        step(4'b0000, 4'h0, 0, 1);
        step(4'b0000, 4'h0, 0, 0);
    endtask

    task automatic test_mask_withdraw();
        step(4'b0001, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd0) begin failures++; $display("FAIL mask_present int=%b id=%0d want 1/0", interrupt, int_id); end
        step(4'b0000, 4'b0001, 0, 0);
        checks++; if (interrupt !== 1'b0 || pending[0] !== 1'b1) begin failures++; $display("FAIL mask_withdraw int=%b pend0=%b want 0/1", interrupt, pending[0]); end
        step(4'b0000, 4'b0001, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd0) begin failures++; $display("FAIL mask_repres int=%b id=%0d want 1/0", interrupt, int_id); end
        step(4'b0000, 4'h0, 1, 0);
        step(4'b0000, 4'h0, 0, 1);
        step(4'b0000, 4'h0, 0, 0);
    endtask

    task automatic test_set_wins();
        step(4'b0010, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 0);
        step(4'b0010, 4'h0, 1, 0);
        checks++; if (pending[1] !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL setwins_pend pend1=%b busy=%b want 1/1", pending[1], busy); end
        step(4'b0000, 4'h0, 0, 1);
        step(4'b0000, 4'h0, 0, 0);
        checks++; if (interrupt !== 1'b1 || int_id !== 2'd1) begin failures++; $display("FAIL setwins_again int=%b id=%0d want 1/1", interrupt, int_id); end
        step(4'b0000, 4'h0, 1, 0);
        step(4'b0000, 4'h0, 0, 1);
        step(4'b0000, 4'h0, 0, 0);
    endtask

    task automatic test_abuse_reset();
        step(4'b0000, 4'h0, 1, 0);
        checks++; if (interrupt !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ack_idle int=%b busy=%b want 0/0", interrupt, busy); end
        step(4'b1000, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 1);
        checks++; if (interrupt !== 1'b1 || busy !== 1'b0 || int_id !== 2'd3) begin failures++; $display("FAIL eoi_req int=%b busy=%b id=%0d want 1/0/3", interrupt, busy, int_id); end
        step(4'b0000, 4'h0, 1, 0);
        step(4'b1010, 4'h0, 0, 0);
        checks++; if (pending !== 4'b1010 || busy !== 1'b1) begin failures++; $display("FAIL svc_pend pend=%b busy=%b want 1010/1", pending, busy); end
        irq_in = 4'b0001;
        #2 reset = 1'b0;
        #1;
        checks++; if ({interrupt, busy, pending, int_id} !== 8'h00 || vector !== 32'h80) begin failures++; $display("FAIL async_reset int=%b busy=%b pend=%b id=%0d vec=%h want all reset", interrupt, busy, pending, int_id, vector); end
        model_reset();
        #2 reset = 1'b1;
        step(4'b0001, 4'h0, 0, 0);
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL held_release pend=%b want 0001", pending); end
        step(4'b0000, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 1, 0);
        step(4'b0000, 4'h0, 0, 1);
    endtask

    task automatic test_random();
        logic [3:0] irq, mask;
        logic ack, e;
        for (int n = 0; n < 600; n++) begin
            irq = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : irq_in & 4'($urandom_range(0, 15));
            mask = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            ack = (m_pres >= 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 9) == 0;
            e = (m_insvc && $urandom_range(0, 2) == 0) || $urandom_range(0, 9) == 0;
            step(irq, mask, ack, e);
            checks++;
            if ({interrupt, busy, int_id, vector, pending} !== {m_pres >= 0, m_insvc, 2'(m_id), 32'h80 + 32'(m_id << 4), m_pend}) begin
                failures++;
                $display("FAIL random_%0d got int=%b busy=%b id=%0d vec=%h pend=%b want int=%b busy=%b id=%0d pend=%b",
                         n, interrupt, busy, int_id, vector, pending, m_pres >= 0, m_insvc, m_id, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask_withdraw();
        test_set_wins();
        test_abuse_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
